// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART-driven system-bus initiator (8N1 command in, response out)
module uart_bus_master #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        system_bus_en,
    output logic        system_bus_rdwr,
    output logic [3:0]  system_bus_mask,
    output logic [31:0] system_bus_addr,
    output logic [31:0] system_bus_wr_data,
    input  logic [31:0] system_bus_rd_data,
    output logic        core_hold,
    output logic        frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {C_IDLE, C_GET_ADDR, C_GET_DATA, C_BUS_REQ, C_BUS_WAIT, C_SEND} cmd_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_valid_q, frame_err_q;

    logic            tx_active_q, txd_q;
    logic [8:0]      tx_shift_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [3:0]      tx_left_q;
    logic            tx_done, tx_idle, tx_load;

    cmd_state_t      cmd_state_q;
    logic            is_write_q, core_hold_q;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     cmd_addr_q, resp_q;
    logic [23:0]     cmd_data_q;
    logic [2:0]      resp_left_q;
    logic            bus_en_q, bus_rdwr_q;
    logic [3:0]      bus_mask_q;
    logic [31:0]     bus_addr_q, bus_wr_data_q;
    logic [31:0]     addr_shift_d, data_shift_d;

    assign addr_shift_d = {cmd_addr_q[23:0], rx_shift_q};
    assign data_shift_d = {cmd_data_q, rx_shift_q};

    // The last stop-bit cycle counts as idle so back-to-back bytes keep exact 10-bit frames
    assign tx_done = tx_active_q && (tx_cnt_q == BIT_LAST) && (tx_left_q == 4'd0);
    assign tx_idle = !tx_active_q || tx_done;
    assign tx_load = (cmd_state_q == C_SEND) && tx_idle && (resp_left_q != 3'd0);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX framer: start-bit glitch filter, mid-bit sampling, stop-bit check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_sync_q) begin
                            rx_valid_q <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            rx_state_q  <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // TX serialiser: start bit on load, then 8 data bits and the stop bit from the shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_q       <= 1'b1;
            tx_active_q <= 1'b0;
            tx_shift_q  <= '1;
            tx_cnt_q    <= '0;
            tx_left_q   <= 4'd0;
        end else if (tx_load) begin
            txd_q       <= 1'b0;
            tx_shift_q  <= {1'b1, resp_q[31:24]};
            tx_cnt_q    <= '0;
            tx_left_q   <= 4'd9;
            tx_active_q <= 1'b1;
        end else if (tx_active_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_left_q == 4'd0) begin
                    tx_active_q <= 1'b0;
                end else begin
                    txd_q      <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_left_q  <= tx_left_q - 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CNT_ONE;
            end
        end
    end

    // Command FSM: collects opcode/address/data, issues one bus cycle, queues the reply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_state_q   <= C_IDLE;
            is_write_q    <= 1'b0;
            core_hold_q   <= 1'b0;
            byte_cnt_q    <= 2'd0;
            cmd_addr_q    <= 32'd0;
            cmd_data_q    <= 24'd0;
            resp_q        <= 32'd0;
            resp_left_q   <= 3'd0;
            bus_en_q      <= 1'b0;
            bus_rdwr_q    <= 1'b0;
            bus_mask_q    <= 4'd0;
            bus_addr_q    <= 32'd0;
            bus_wr_data_q <= 32'd0;
        end else begin
            case (cmd_state_q)
                C_IDLE: begin
                    if (rx_valid_q) begin
                        if (rx_shift_q == 8'h57 || rx_shift_q == 8'h52) begin
                            is_write_q  <= (rx_shift_q == 8'h57);
                            core_hold_q <= 1'b1;
                            byte_cnt_q  <= 2'd0;
                            cmd_state_q <= C_GET_ADDR;
                        end else begin
                            resp_q      <= {8'h3F, 24'd0};
                            resp_left_q <= 3'd1;
                            cmd_state_q <= C_SEND;
                        end
                    end
                end
                C_GET_ADDR: begin
                    if (rx_valid_q) begin
                        cmd_addr_q <= addr_shift_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (is_write_q) begin
                                cmd_state_q <= C_GET_DATA;
                            end else begin
                                bus_en_q    <= 1'b1;
                                bus_rdwr_q  <= 1'b0;
                                bus_mask_q  <= 4'b1111;
                                bus_addr_q  <= {addr_shift_d[31:2], 2'b00};
                                cmd_state_q <= C_BUS_REQ;
                            end
                        end
                    end
                end
                C_GET_DATA: begin
                    if (rx_valid_q) begin
                        cmd_data_q <= data_shift_d[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            bus_en_q      <= 1'b1;
                            bus_rdwr_q    <= 1'b1;
                            bus_mask_q    <= 4'b1111;
                            bus_addr_q    <= {cmd_addr_q[31:2], 2'b00};
                            bus_wr_data_q <= data_shift_d;
                            cmd_state_q   <= C_BUS_REQ;
                        end
                    end
                end
                C_BUS_REQ: begin
                    bus_en_q    <= 1'b0;
                    cmd_state_q <= C_BUS_WAIT;
                end
                C_BUS_WAIT: begin
                    core_hold_q <= 1'b0;
                    if (is_write_q) begin
                        resp_q      <= {8'h4B, 24'd0};
                        resp_left_q <= 3'd1;
                    end else begin
                        resp_q      <= system_bus_rd_data;
                        resp_left_q <= 3'd4;
                    end
                    cmd_state_q <= C_SEND;
                end
                C_SEND: begin
                    if (tx_load) begin
                        resp_q      <= {resp_q[23:0], 8'd0};
                        resp_left_q <= resp_left_q - 3'd1;
                    end else if (resp_left_q == 3'd0 && tx_idle) begin
                        cmd_state_q <= C_IDLE;
                    end
                end
                default: cmd_state_q <= C_IDLE;
            endcase
        end
    end

    assign uart_txd_o         = txd_q;
    assign system_bus_en      = bus_en_q;
    assign system_bus_rdwr    = bus_rdwr_q;
    assign system_bus_mask    = bus_mask_q;
    assign system_bus_addr    = bus_addr_q;
    assign system_bus_wr_data = bus_wr_data_q;
    assign core_hold          = core_hold_q;
    assign frame_err          = frame_err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - self-checking bench for uart_bus_master
module tb_uart_bus_master;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        txd;
    logic        bus_en, bus_rdwr;
    logic [3:0]  bus_mask;
    logic [31:0] bus_addr, bus_wdata, rd_data;
    logic        core_hold, frame_err;
    logic [31:0] mem_word;

    uart_bus_master #(.CLKS_PER_BIT(CPB)) dut (
        .clk                (clk),
        .rst                (rst),
        .uart_rxd_i         (rxd),
        .uart_txd_o         (txd),
        .system_bus_en      (bus_en),
        .system_bus_rdwr    (bus_rdwr),
        .system_bus_mask    (bus_mask),
        .system_bus_addr    (bus_addr),
        .system_bus_wr_data (bus_wdata),
        .system_bus_rd_data (rd_data),
        .core_hold          (core_hold),
        .frame_err          (frame_err)
    );

    always #5 clk = ~clk;

    // Bus memory: read data valid only in the cycle after a read strobe
    always @(posedge clk) rd_data <= (bus_en && !bus_rdwr) ? mem_word : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          en_total = 0, fe_total = 0, hold_total = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_rdwr;
    logic [3:0]  cap_mask;

    always @(negedge clk) begin
        if (bus_en) begin
            en_total  <= en_total + 1;
            cap_addr  <= bus_addr;
            cap_wdata <= bus_wdata;
            cap_rdwr  <= bus_rdwr;
            cap_mask  <= bus_mask;
        end
        if (frame_err) fe_total   <= fe_total + 1;
        if (core_hold) hold_total <= hold_total + 1;
    end

    logic [7:0] tx_bytes [0:255];
    int         tx_time  [0:255];
    int         n_tx = 0;

    initial begin : tx_mon
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                tx_bytes[n_tx[7:0]] = b;
                tx_time[n_tx[7:0]]  = t0;
                n_tx = n_tx + 1;
            end
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(CPB);
        end
        rxd = stop;
        wait_cyc(CPB);
        rxd = 1'b1;
        wait_cyc(2 * CPB);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op, 1'b1);
        if (op == 8'h57 || op == 8'h52)
            for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        if (op == 8'h57)
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic wait_tx(input int want, input string name);
        int k;
        k = 0;
        while (n_tx < want && k < 3000) begin
            wait_cyc(1);
            k++;
        end
        check({name, "_reply_timeout"}, 32'(n_tx >= want), 32'd1);
        wait_cyc(60);
    endtask

    task automatic check_reply(input string name, input int base, input int nrep, input logic [31:0] rep);
        check({name, "_reply_count"}, 32'(n_tx - base), 32'(nrep));
        for (int i = 0; i < nrep; i++) begin
            check({name, "_reply_byte"}, {24'd0, tx_bytes[(base + i) % 256]}, {24'd0, rep[31 - 8*i -: 8]});
            if (i > 0)
                check({name, "_frame_len"}, 32'(tx_time[(base + i) % 256] - tx_time[(base + i - 1) % 256]), 32'd40);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_txd"},       {31'd0, txd},       32'd1);
        check({name, "_en"},        {31'd0, bus_en},    32'd0);
        check({name, "_rdwr"},      {31'd0, bus_rdwr},  32'd0);
        check({name, "_mask"},      {28'd0, bus_mask},  32'd0);
        check({name, "_addr"},      bus_addr,           32'd0);
        check({name, "_wdata"},     bus_wdata,          32'd0);
        check({name, "_core_hold"}, {31'd0, core_hold}, 32'd0);
        check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd_word;
        int          exp_en;
        logic [31:0] exp_addr;
        logic        exp_rdwr;
        logic [31:0] exp_wdata;
        int          nrep;
        logic [31:0] exp_rep;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int b_tx, b_en, b_fe, b_hold, k;
        vecs[0] = '{8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1, 32'h4B00_0000};
        vecs[1] = '{8'h52, 32'h0000_0103, 32'h0,         32'h1234_5678, 1, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 4, 32'h1234_5678};
        vecs[2] = '{8'h41, 32'h0,         32'h0,         32'h0,         0, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 1, 32'h3F00_0000};
        vecs[3] = '{8'h57, 32'h8000_0007, 32'h0102_0304, 32'h0,         1, 32'h8000_0004, 1'b1, 32'h0102_0304, 1, 32'h4B00_0000};
        vecs[4] = '{8'h52, 32'hFFFF_FFFE, 32'h0,         32'hA5C3_0F99, 1, 32'hFFFF_FFFC, 1'b0, 32'h0102_0304, 4, 32'hA5C3_0F99};
        vecs[5] = '{8'h00, 32'h0,         32'h0,         32'h0,         0, 32'hFFFF_FFFC, 1'b0, 32'h0102_0304, 1, 32'h3F00_0000};

        rst = 1'b1;
        rxd = 1'b1;
        mem_word = 32'h0;
        wait_cyc(3);
        check_reset_state("reset");
        rst = 1'b0;
        wait_cyc(5);

        for (int v = 0; v < 6; v++) begin
            b_tx = n_tx; b_en = en_total; b_hold = hold_total;
            mem_word = vecs[v].rd_word;
            send_cmd(vecs[v].op, vecs[v].addr, vecs[v].data);
            wait_tx(b_tx + vecs[v].nrep, "vec");
            check_reply("vec", b_tx, vecs[v].nrep, vecs[v].exp_rep);
            check("vec_en_count", 32'(en_total - b_en), 32'(vecs[v].exp_en));
            check("vec_hold_seen", 32'(hold_total != b_hold), 32'(vecs[v].exp_en != 0));
            if (vecs[v].exp_en != 0) begin
                check("vec_strobe_addr",  cap_addr,  vecs[v].exp_addr);
                check("vec_strobe_rdwr",  {31'd0, cap_rdwr}, {31'd0, vecs[v].exp_rdwr});
                check("vec_strobe_mask",  {28'd0, cap_mask}, 32'hF);
                check("vec_strobe_wdata", cap_wdata, vecs[v].exp_wdata);
            end
            check("vec_hold_addr",  bus_addr,  vecs[v].exp_addr);
            check("vec_hold_rdwr",  {31'd0, bus_rdwr}, {31'd0, vecs[v].exp_rdwr});
            check("vec_hold_wdata", bus_wdata, vecs[v].exp_wdata);
            check("vec_hold_mask",  {28'd0, bus_mask}, 32'hF);
            check("vec_idle_hold",  {31'd0, core_hold}, 32'd0);
        end

        // Bad stop bit on the second address byte: byte dropped, command completes with the next good bytes
        b_tx = n_tx; b_en = en_total; b_fe = fe_total;
        mem_word = 32'hCAFE_F00D;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b0);
        check("ferr_hold_kept", {31'd0, core_hold}, 32'd1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_tx(b_tx + 4, "ferr");
        check("ferr_pulses", 32'(fe_total - b_fe), 32'd1);
        check("ferr_en_count", 32'(en_total - b_en), 32'd1);
        check("ferr_addr", cap_addr, 32'h0022_3344);
        check("ferr_rdwr", {31'd0, cap_rdwr}, 32'd0);
        check_reply("ferr", b_tx, 4, 32'hCAFE_F00D);

        // Two-cycle low glitch in idle must not produce a byte
        b_tx = n_tx; b_fe = fe_total; b_hold = hold_total;
        rxd = 1'b0;
        wait_cyc(2);
        rxd = 1'b1;
        wait_cyc(100);
        check("glitch_no_reply", 32'(n_tx - b_tx), 32'd0);
        check("glitch_no_ferr", 32'(fe_total - b_fe), 32'd0);
        check("glitch_no_hold", 32'(hold_total - b_hold), 32'd0);
        send_cmd(8'h41, 32'h0, 32'h0);
        wait_tx(b_tx + 1, "glitch");
        check_reply("glitch", b_tx, 1, 32'h3F00_0000);

        // Reset while a reply byte is on the wire
        send_byte(8'h41, 1'b1);
        k = 0;
        while (txd !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_tx_started", {31'd0, txd}, 32'd0);
        wait_cyc(10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid_tx");
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(60);

        b_tx = n_tx; b_en = en_total;
        mem_word = 32'h0BAD_BEEF;
        send_cmd(8'h52, 32'h0000_0010, 32'h0);
        wait_tx(b_tx + 4, "post_rst");
        check("post_rst_en_count", 32'(en_total - b_en), 32'd1);
        check("post_rst_addr", cap_addr, 32'h0000_0010);
        check_reply("post_rst", b_tx, 4, 32'h0BAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
